rr_onehot_arbiter: RTL

- 16-requester round-robin arbiter.
- Shares one downstream resource among 16 agents.
- Grant is presented both as a one-hot vector (16 bit) and as a binary index (4 bit). The index is the same value our 4-to-16 one-hot encoder consumes.
- Sits between the requesting agents and the shared datapath. Enforces fairness and a bounded hold time per grant.

---
 rtl/rr_onehot_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: 16-way round-robin arbiter with bounded hold.
// Ports: clk, rst (async high), req[N], done -> gnt[N] one-hot,
//   gnt_idx[IDX_W], gnt_valid, timeout (one-cycle forced-release pulse).
module rr_onehot_arbiter #(
   parameter int N        = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0]   HOLD_MAX = 8'(MAX_HOLD);
   localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [7:0]       hold_cnt;
   logic [7:0]       hold_nxt;
   logic [N-1:0]     gnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             valid_nxt;
   logic             timeout_nxt;

   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] cand;
   logic             pick_vld;
   logic             holder_req;
   logic             voluntary;
   logic             hold_max;

   assign holder_req = req[gnt_idx];
   assign voluntary  = done | ~holder_req;
   assign hold_max   = (hold_cnt == HOLD_MAX);

   // Rotating priority scan: walk from the farthest offset down to
   // offset 0 so the last hit (closest to ptr) is the one kept.
   // Index arithmetic wraps naturally because N == 2**IDX_W.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // State register plus the registered outputs and bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= idx_nxt;
         gnt_valid <= valid_nxt;
         timeout   <= timeout_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (pick_vld) state_nxt = GRANT;
         end
         GRANT: begin
            if (voluntary || hold_max) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath logic: values loaded into the output registers.
   // done is simply not looked at in IDLE.
   always_comb begin
      gnt_nxt     = gnt;
      idx_nxt     = gnt_idx;
      valid_nxt   = gnt_valid;
      timeout_nxt = 1'b0;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               gnt_nxt   = ONE << pick;
               idx_nxt   = pick;
               valid_nxt = 1'b1;
               hold_nxt  = 8'd1;
               ptr_nxt   = pick + IDX_W'(1);
            end else begin
               gnt_nxt   = '0;
               valid_nxt = 1'b0;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (voluntary || hold_max) begin
               gnt_nxt     = '0;
               valid_nxt   = 1'b0;
               hold_nxt    = '0;
               // A voluntary release takes precedence over the limit.
               timeout_nxt = ~voluntary;
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
         end
      endcase
   end

endmodule
